// File: rtl/spi_pkg.sv
// Shared constants for the SPI register-file controller: FSM encodings,
// R/W bit encoding and the frame-length helper.
package spi_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    // First frame bit: 1 = write, 0 = read
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Total bits in one frame: R/W + address + data
    function automatic int frame_len(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/spi_regfile_ctrl_if.sv
// SPI pin bundle. The controller (host/bench) drives sclk/copi/ncs,
// the peripheral drives cipo and its pad output enable.
interface spi_regfile_ctrl_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus a one-clk edge pulse.
// The edge direction is the current synchronised level (high = rise).
// Resets to 0 so a pin already low at reset release produces no fall.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchroniser and keep one older sample
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_regfile_ctrl.sv
// SPI mode-0 peripheral with a read/write configuration register bank.
// sclk is oversampled on clk; all state lives in the clk domain.
module spi_regfile_ctrl
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_regfile_ctrl_if.slave          spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int CNT_W = $clog2(frame_len(ADDR_W, DATA_W));

    logic sclk_s, sclk_edge, ncs_s, ncs_edge;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic copi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(spi.sclk), .q_o(sclk_s), .edge_o(sclk_edge)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk(clk), .rst(rst), .d_i(spi.ncs), .q_o(ncs_s), .edge_o(ncs_edge)
    );

    assign sclk_rise = sclk_edge &  sclk_s;
    assign sclk_fall = sclk_edge & ~sclk_s;
    assign ncs_rise  = ncs_edge  &  ncs_s;
    assign ncs_fall  = ncs_edge  & ~ncs_s;
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];

    // copi only needs a level synchroniser; it is sampled on sclk rise
    always_ff @(posedge clk) begin
        if (rst) copi_sync_q <= '0;
        else     copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
    end

    logic [2:0]                             state_q, state_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic                                   rw_q, rw_d;
    logic [ADDR_W-1:0]                      addr_q, addr_d, addr_shift;
    logic [DATA_W-1:0]                      data_q, data_d, data_shift;
    logic [DATA_W-1:0]                      shout_q, shout_d, rd_val;
    logic                                   cipo_q, cipo_d, cipo_oe_q, cipo_oe_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]        regs_q, regs_d;
    logic                                   wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]                      wr_addr_q, wr_addr_d;
    logic                                   frame_err_q, frame_err_d;
    logic                                   rd_hit, wr_hit;

    // Shift registers with the incoming bit appended; address decode for
    // the read load (next address) and the write commit (held address)
    always_comb begin
        addr_shift    = addr_q << 1;
        addr_shift[0] = copi_s;
        data_shift    = data_q << 1;
        data_shift[0] = copi_s;
        rd_val = '0;
        rd_hit = 1'b0;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_shift == ADDR_W'(i)) begin
                rd_val = regs_q[i];
                rd_hit = 1'b1;
            end
            if (addr_q == ADDR_W'(i)) wr_hit = 1'b1;
        end
    end

    // Frame FSM: next-state, shift-out and register-bank update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        shout_d     = shout_q;
        cipo_d      = cipo_q;
        cipo_oe_d   = ~ncs_s;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = frame_err_q;
        case (state_q)
            ST_IDLE: begin
                cipo_d = 1'b0;
                if (ncs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                cipo_d = 1'b0;
                if (ncs_rise) state_d = ST_IDLE;
            end
            default: begin
                if (ncs_rise) begin
                    // early deselect: drop the frame
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    cipo_d      = 1'b0;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    if (state_q == ST_CMD) begin
                        rw_d    = copi_s;
                        state_d = ST_ADDR;
                        cnt_d   = '0;
                    end else if (state_q == ST_ADDR) begin
                        addr_d = addr_shift;
                        if (cnt_q == CNT_W'(ADDR_W-1)) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                            shout_d = (rw_q == RW_READ && rd_hit) ? rd_val : '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        data_d = data_shift;
                        if (cnt_q == CNT_W'(DATA_W-1)) begin
                            state_d     = ST_HOLD;
                            cnt_d       = '0;
                            cipo_d      = 1'b0;
                            frame_err_d = ~wr_hit;
                            if (wr_hit && rw_q == RW_WRITE) begin
                                for (int i = 0; i < NUM_REGS; i++)
                                    if (addr_q == ADDR_W'(i)) regs_d[i] = data_shift;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else if (sclk_fall && state_q == ST_DATA && rw_q == RW_READ) begin
                    cipo_d  = shout_q[DATA_W-1];
                    shout_d = shout_q << 1;
                end
            end
        endcase
    end

    // State registers; rst wins over any SPI activity
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            shout_q     <= '0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            shout_q     <= shout_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= cipo_oe_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = cipo_oe_q;
    assign regs_flat   = regs_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_ctrl.sv
// Bench for spi_regfile_ctrl: directed vector table, hand sequences for
// reset/back-to-back/HOLD cases, then random frames against a register model.
module tb_spi_regfile_ctrl;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int HALF     = 80;   // sclk half period: clk/16

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_regfile_ctrl_if bus();
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       frame_err;

    spi_regfile_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi(bus), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int strobe_cycles = 0;

    // every clk with the strobe high counts; a stretched pulse shows up here
    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cycles++;

    // behavioural model
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic              m_err;
    int                m_strobes;
    logic [ADDR_W-1:0] m_waddr;

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        int          nbits;
        logic [7:0]  exp_rd;
        logic        exp_err;
        int          chk_idx;
        logic [7:0]  chk_val;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_err   = 1'b0;
        m_waddr = '0;
    endtask

    task automatic model_apply(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                               input int nbits, output logic [7:0] exp_rd);
        exp_rd = '0;
        if (nbits < 16 || addr >= NUM_REGS) begin
            m_err = 1'b1;
        end else begin
            m_err = 1'b0;
            if (rw) begin
                m_regs[addr] = data;
                m_strobes++;
                m_waddr = addr;
            end else begin
                exp_rd = m_regs[addr];
            end
        end
    endtask

    task automatic check_state(input string tag);
        logic [NUM_REGS*DATA_W-1:0] exp_flat;
        for (int i = 0; i < NUM_REGS; i++) exp_flat[i*DATA_W +: DATA_W] = m_regs[i];
        chk({tag, "_regs"},    regs_flat,     exp_flat);
        chk({tag, "_err"},     frame_err,     m_err);
        chk({tag, "_strobes"}, strobe_cycles, m_strobes);
        chk({tag, "_wraddr"},  wr_addr,       m_waddr);
    endtask

    task automatic spi_start();
        bus.ncs = 1'b0;
        #(HALF);
    endtask

    task automatic spi_bit(input logic b, output logic c);
        bus.copi = b;
        #(HALF);
        bus.sclk = 1'b1;
        c = bus.cipo;
        #(HALF);
        bus.sclk = 1'b0;
    endtask

    task automatic spi_end(output logic oe);
        #(HALF);
        oe = bus.cipo_oe;
        bus.ncs = 1'b1;
        #(4*HALF);
    endtask

    // one frame of nbits; bits past 16 are random filler clocked in HOLD
    task automatic frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                         input int nbits, output logic [7:0] rd, output logic oe, output logic cipo_ok);
        logic [15:0] bits;
        logic b, c;
        bits    = {rw, addr, data};
        rd      = '0;
        cipo_ok = 1'b1;
        spi_start();
        for (int i = 0; i < nbits; i++) begin
            b = (i < 16) ? bits[15-i] : 1'($urandom_range(0, 1));
            spi_bit(b, c);
            if (i >= 8 && i < 16 && rw == 1'b0) rd = {rd[6:0], c};
            else if (c !== 1'b0) cipo_ok = 1'b0;
        end
        spi_end(oe);
    endtask

    task automatic run_frame(input string tag, input logic rw, input logic [6:0] addr,
                             input logic [7:0] data, input int nbits);
        logic [7:0] rd, exp_rd;
        logic oe, ok;
        frame(rw, addr, data, nbits, rd, oe, ok);
        model_apply(rw, addr, data, nbits, exp_rd);
        if (!rw && nbits >= 16) chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_oe_low"}, oe, 1'b1);
        chk({tag, "_oe_high"}, bus.cipo_oe, 1'b0);
        chk({tag, "_cipo_idle"}, ok, 1'b1);
        check_state(tag);
    endtask

    vec_t vecs [10];

    initial begin
        logic c, oe;
        logic [15:0] bits;

        vecs[0] = '{1'b1, 7'h02, 8'hA5, 16, 8'h00, 1'b0, 2, 8'hA5};
        vecs[1] = '{1'b0, 7'h02, 8'h00, 16, 8'hA5, 1'b0, 2, 8'hA5};
        vecs[2] = '{1'b1, 7'h10, 8'hFF, 16, 8'h00, 1'b1, 0, 8'h00};
        vecs[3] = '{1'b1, 7'h00, 8'h3C, 16, 8'h00, 1'b0, 0, 8'h3C};
        vecs[4] = '{1'b1, 7'h04, 8'h77, 10, 8'h00, 1'b1, 4, 8'h00};
        vecs[5] = '{1'b1, 7'h04, 8'h77, 16, 8'h00, 1'b0, 4, 8'h77};
        vecs[6] = '{1'b0, 7'h05, 8'h00, 16, 8'h00, 1'b1, 4, 8'h77};
        vecs[7] = '{1'b0, 7'h00, 8'h00, 16, 8'h3C, 1'b0, 0, 8'h3C};
        vecs[8] = '{1'b1, 7'h7F, 8'h01, 16, 8'h00, 1'b1, 1, 8'h00};
        vecs[9] = '{1'b0, 7'h04, 8'h00, 12, 8'h00, 1'b1, 4, 8'h77};

        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        rst      = 1'b1;
        model_reset();
        m_strobes = 0;
        repeat (5) @(negedge clk);
        chk("rst_regs", regs_flat, '0);
        chk("rst_cipo", bus.cipo, 1'b0);
        chk("rst_oe", bus.cipo_oe, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_wraddr", wr_addr, '0);
        chk("rst_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // directed table
        for (int v = 0; v < 10; v++) begin
            logic [7:0] rd;
            logic ok;
            int s0;
            s0 = strobe_cycles;
            frame(vecs[v].rw, vecs[v].addr, vecs[v].data, vecs[v].nbits, rd, oe, ok);
            if (!vecs[v].rw && vecs[v].nbits >= 16) chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_err", v), frame_err, vecs[v].exp_err);
            chk($sformatf("vec%0d_reg", v), regs_flat[vecs[v].chk_idx*8 +: 8], vecs[v].chk_val);
            chk($sformatf("vec%0d_strobe", v), strobe_cycles - s0,
                (vecs[v].rw && vecs[v].nbits >= 16 && vecs[v].addr < NUM_REGS) ? 1 : 0);
            chk($sformatf("vec%0d_oe", v), oe, 1'b1);
            chk($sformatf("vec%0d_cipo", v), ok, 1'b1);
            begin
                logic [7:0] dummy;
                model_apply(vecs[v].rw, vecs[v].addr, vecs[v].data, vecs[v].nbits, dummy);
            end
        end
        check_state("table_end");

        // reset in the middle of a write's data phase, ncs held low
        bits = 16'h8155;
        spi_start();
        for (int i = 0; i < 12; i++) spi_bit(bits[15-i], c);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("rstmid");
        for (int i = 12; i < 16; i++) spi_bit(bits[15-i], c);
        repeat (6) @(negedge clk);
        check_state("rstmid_tail");
        spi_end(oe);
        check_state("rstmid_end");
        run_frame("after_rst", 1'b1, 7'h01, 8'h55, 16);

        // back-to-back writes, the second followed by 20 HOLD clocks
        run_frame("b2b0", 1'b1, 7'h00, 8'h11, 16);
        run_frame("b2b1", 1'b1, 7'h03, 8'h22, 36);
        chk("b2b_reg0", regs_flat[7:0], 8'h11);
        chk("b2b_reg3", regs_flat[31:24], 8'h22);

        // random frames against the model
        for (int n = 0; n < 40; n++) begin
            int sel, nb;
            logic [6:0] a;
            sel = $urandom_range(0, 9);
            nb  = (sel == 0) ? $urandom_range(1, 15) : (sel == 1) ? 16 + $urandom_range(1, 8) : 16;
            a   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
            run_frame($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, 8'($urandom), nb);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/spi_regfile_ctrl.md
Name: spi_regfile_ctrl

Overview:
- Parametrised SPI (mode 0) peripheral giving the host read/write access to a bank of configuration registers.
- Successor to the write-only 5-register interface. Adds:
  - generic register count and widths
  - read-back on cipo
  - per-write strobe
  - clean abort on early ncs deassertion
- All logic is clocked on the system clock; sclk is treated as data, never as a clock.
- Sits between the chip pins (sclk/copi/ncs/cipo) and the output-enable/PWM configuration consumers.

Parameters:
- NUM_REGS, 5, number of implemented registers (1..2**ADDR_W).
- ADDR_W, 7, address field width in the frame.
- DATA_W, 8, register and data field width.
- SYNC_STAGES, 2, synchroniser depth on sclk/copi/ncs (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sclk  in  1  SPI clock, asynchronous to clk
- copi  in  1  controller-out/peripheral-in, asynchronous
- ncs  in  1  chip select, active-low, asynchronous
- cipo  out  1  peripheral-out data
- cipo_oe  out  1  high while ncs is synchronised-low (pad tristate control)
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i at [i*DATA_W +: DATA_W]
- wr_strobe  out  1  one-clk pulse when a register is written
- wr_addr  out  ADDR_W  address of the last write, valid with wr_strobe
- frame_err  out  1  sticky: set on an aborted or out-of-range frame; cleared by rst or a completed valid frame

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous active-high. It clears all state regardless of SPI activity, including mid-frame.
  - Reset values: regs_flat=0, cipo=0, cipo_oe=0, wr_strobe=0, wr_addr=0, frame_err=0, FSM=IDLE, bit counter=0.
- Input synchronisation:
  - sclk, copi and ncs each pass through SYNC_STAGES flops.
  - sclk rise/fall are detected from the last two synchronised samples.
  - Requirement: f_sclk <= f_clk/8.
- Frame format, MSB first, (1+ADDR_W+DATA_W) bits:
  - bit 0 = R/W (1 = write, 0 = read)
  - next ADDR_W bits = address
  - next DATA_W bits = data
- Sampling edges:
  - copi is sampled on synchronised sclk rise, only while synchronised ncs is low.
  - cipo changes only on synchronised sclk fall.
- FSM states: IDLE, CMD, ADDR, DATA, HOLD.
  - IDLE -> CMD when ncs falls. Bit counter cleared.
  - CMD -> ADDR after 1 rising edge. R/W latched.
  - ADDR -> DATA after ADDR_W rising edges.
    - On entry, for a read: shift-out register loaded with reg[addr], or 0 if addr >= NUM_REGS.
    - MSB is driven on cipo at the next sclk fall, so it is valid before the first data rise.
  - DATA -> HOLD after DATA_W rising edges.
    - Write with addr < NUM_REGS: register updated on the clk after the last rising edge; wr_strobe pulses for exactly 1 clk with wr_addr=addr.
    - Write with addr >= NUM_REGS: no update, no strobe, frame_err=1.
    - Read: no update.
  - HOLD: further sclk edges are ignored and cipo holds 0. HOLD -> IDLE when ncs rises.
  - Any state other than IDLE/HOLD with ncs rising -> IDLE. Frame discarded, no register change, frame_err=1.
- Other rules:
  - cipo outside the DATA read phase is 0.
  - A completed valid frame (write in range, or any read in range) clears frame_err.
  - Back-to-back frames need ncs high for at least 2 clk after synchronisation. The FSM must return to IDLE before the next fall.
  - If ncs is already low when rst deasserts, the FSM waits in IDLE for an ncs rise then fall. No partial frame is accepted.
  - Register reads see the value as of ADDR->DATA entry. A simultaneous internal update is impossible, since there is a single writer.

Decomposition:
- Shared package spi_pkg:
  - FSM state enum
  - frame-length localparam function (1+ADDR_W+DATA_W)
  - R/W bit encoding constants
- One sub-module, spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect, instantiated for sclk and ncs. copi uses the synchroniser only.
- Register bank and FSM stay in the top module.

Test Plan (all tests use defaults):
- Write 0x82,0xA5 (R/W=1, addr=2) -> regs_flat[23:16]=0xA5; wr_strobe high 1 clk with wr_addr=2; other registers 0; frame_err=0.
- After that write, read frame 0x02 then 8 dummy bits -> cipo shifts 1,0,1,0,0,1,0,1 (0xA5), stable on each sclk rise; cipo_oe high only while ncs low.
- Write 0x90,0xFF (addr=0x10, out of range) -> no register changes, no wr_strobe, frame_err=1. Next valid write 0x80,0x3C -> reg0=0x3C, frame_err=0.
- Write 0x84,0x77 with ncs raised after 10 bits -> reg4 unchanged (0), no strobe, frame_err=1. A following full write 0x84,0x77 -> reg4=0x77.
- Assert rst for 1 clk in the middle of the data phase of write 0x81,0x55 -> all registers 0, FSM IDLE. The remaining bits of that frame are ignored until ncs cycles high then low.
- Two back-to-back writes 0x80,0x11 and 0x83,0x22 with ncs high for 2 sclk periods -> reg0=0x11, reg3=0x22, exactly 2 wr_strobe pulses; 20 extra sclk cycles in HOLD cause no change.
